// File: rtl/serial_pkg.sv
// Shared definitions for the serial deframer: FSM states, line levels, default width.
package serial_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   DEF_WIDTH  = 8;
endpackage

// File: rtl/deframe_outbuf.sv
// One-entry valid/ready holding register; a word arriving while full is dropped with an overrun pulse.
module deframe_outbuf import serial_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);
  logic pop;
  assign pop = dout_valid && ready;

  always_ff @(posedge clk) begin
    if (!clr) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        // A pop in the same cycle frees the slot for the new word.
        if (!dout_valid || pop) begin
          dout       <= data;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (pop) begin
        dout_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/serial_deframer.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Define PARITY_CHECK_EN to expect and check the parity bit.
module serial_deframer import serial_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             framing_err,
  output logic             parity_err,
  output logic             overrun
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic             word_done;

`ifdef PARITY_CHECK_EN
  logic par_bad;
  assign word_done = (state == STOP) && (din == STOP_BIT) && !par_bad;
`else
  assign word_done = (state == STOP) && (din == STOP_BIT);
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clr) begin
      state       <= IDLE;
      cnt         <= '0;
      sreg        <= '0;
      framing_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_bad     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      framing_err <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err  <= 1'b0;
`endif
      case (state)
        IDLE: if (din == START_BIT) begin
          state <= DATA;
          cnt   <= '0;
        end
        DATA: begin
          // Right shift: the first bit received ends up in the LSB.
          sreg <= {din, sreg[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) begin
`ifdef PARITY_CHECK_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          par_bad <= (din != ^sreg);
          state   <= STOP;
        end
`endif
        STOP: begin
          if (din != STOP_BIT) framing_err <= 1'b1;
`ifdef PARITY_CHECK_EN
          else if (par_bad) parity_err <= 1'b1;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  deframe_outbuf #(.WIDTH(WIDTH)) u_outbuf (
    .clk        (clk),
    .clr        (clr),
    .load       (word_done),
    .data       (sreg),
    .ready      (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overrun    (overrun)
  );
endmodule

// File: tb/tb_serial_deframer.sv
// Directed plus random frames against a frame-level model of the deframer and its output buffer.
module tb_serial_deframer;
  localparam int W = 8;
`ifdef PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0, clr = 1'b0, din = 1'b1, dout_ready = 1'b0;
  logic [W-1:0] dout;
  logic dout_valid, framing_err, parity_err, overrun;

  serial_deframer #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .din(din), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .framing_err(framing_err), .parity_err(parity_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic         exp_valid = 1'b0;
  logic [W-1:0] exp_dout  = '0;
  logic         exp_fe = 1'b0, exp_pe = 1'b0, exp_ov = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},   32'(dout_valid),  32'(exp_valid));
    chk({tag, ".dout"},    32'(dout),        32'(exp_dout));
    chk({tag, ".framing"}, 32'(framing_err), 32'(exp_fe));
    chk({tag, ".parity"},  32'(parity_err),  32'(exp_pe));
    chk({tag, ".overrun"}, 32'(overrun),     32'(exp_ov));
  endtask

  task automatic step(input logic b, input logic rdy);
    din = b;
    dout_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) begin
      step(1'b1, rdy);
      if (exp_valid && rdy) exp_valid = 1'b0;
      exp_fe = 1'b0; exp_pe = 1'b0; exp_ov = 1'b0;
      check_all("idle");
    end
  endtask

  // rb: ready through start/data/parity bits; rs: ready on the stop-bit cycle.
  task automatic frame(input string tag, input logic [W-1:0] data, input logic stop,
                       input logic pflip, input logic rb, input logic rs);
    logic pop, perr, good;
    step(1'b0, rb);
    if (exp_valid && rb) exp_valid = 1'b0;
    for (int i = 0; i < W; i++) step(data[i], rb);
    if (PAR) step(^data ^ pflip, rb);
    step(stop, rs);
    pop  = exp_valid && rs;
    perr = PAR && pflip;
    good = stop && !perr;
    exp_fe = !stop;
    exp_pe = stop && perr;
    exp_ov = 1'b0;
    if (good && (!exp_valid || pop)) begin
      exp_dout  = data;
      exp_valid = 1'b1;
    end else begin
      if (good) exp_ov = 1'b1;
      if (pop) exp_valid = 1'b0;
    end
    check_all(tag);
  endtask

  initial begin
    clr = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check_all("reset");
    clr = 1'b1;
    idle(2, 1'b0);

    frame("f4a", 8'h4A, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);

    frame("ferr", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);
    frame("f3c", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);

    frame("f11", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    frame("f22ov", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1);

    frame("f33", 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    frame("f44pop", 8'h44, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    frame("par_ok", 8'h03, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);
    frame("par_bad", 8'h03, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1, 1'b1);

    // Hold a word, then reset four data bits into a new frame.
    frame("fhold", 8'h5E, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b0);
    clr = 1'b0;
    step(1'b1, 1'b0);
    clr = 1'b1;
    exp_valid = 1'b0; exp_dout = '0; exp_fe = 1'b0; exp_pe = 1'b0; exp_ov = 1'b0;
    check_all("midreset");
    idle(1, 1'b0);
    frame("fa5", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);

    for (int k = 0; k < 40; k++) begin
      frame("rand", W'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    idle(2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
